// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor, diff = a - b, LSB
//               first, one bit per clock through a single borrow flip-flop.
//               start/busy/done handshake; diff/bout/ovf/zero are registered
//               and only change when an operation completes (or on reset).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  // Holds the WIDTH-1 difference bits already produced; the bit produced on
  // the final edge is appended combinationally so it lands in diff directly.
  logic [WIDTH-2:0] r_res_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic             r_sa;
  logic             r_sb;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_accept;
  logic             w_finish;

  // One full-subtractor cell plus the next result word and control decodes
  always_comb begin
    w_x           = r_a_sr[0];
    w_y           = r_b_sr[0];
    w_d           = w_x ^ w_y ^ r_borrow;
    w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    w_res_next    = {w_d, r_res_sr};
    w_last        = (r_count == CW'(WIDTH - 1));
    w_finish      = (r_state == S_SHIFT) && w_last;
    // The closing edge of the one-cycle DONE state is also an acceptance
    // edge, so a held start yields a new operation every WIDTH+1 cycles.
    w_accept      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // Sequencer: operand capture, serial shifting and bit counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_sa     <= a[WIDTH-1];
            r_sb     <= b[WIDTH-1];
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_state  <= S_SHIFT;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_next[WIDTH-1:1];
          r_borrow <= w_borrow_next;
          r_count  <= r_count + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result, flags and handshake outputs; results update only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        busy <= 1'b1;
      end
      if (w_finish) begin
        diff <= w_res_next;
        bout <= w_borrow_next;
        ovf  <= (r_sa != r_sb) && (w_res_next[WIDTH-1] != r_sa);
        zero <= (w_res_next == '0);
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor. Accepted operations
//               are queued with their acceptance edge; a negedge monitor
//               computes results arithmetically and checks every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;
  logic         busy;
  logic         done;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           k;
  } op_t;

  op_t q[$];
  int  cyc     = 0;
  int  free_at = 0;
  int  vectors = 0;
  int  miscompares = 0;

  logic [W-1:0] exp_diff = '0;
  logic         exp_bout = 1'b0;
  logic         exp_ovf  = 1'b0;
  logic         exp_zero = 1'b1;
  logic         busy_exp;
  logic         done_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Acceptance model: a start is taken when the block is free; an accepted
  // operation occupies WIDTH+1 edges before the next start can be taken.
  always @(posedge clk) begin
    if (!rst_n) begin
      free_at <= 0;
    end else if (start && cyc >= free_at) begin
      q.push_back('{a: a_in, b: b_in, k: cyc});
      free_at <= cyc + W + 1;
    end
    cyc <= cyc + 1;
  end

  // Monitor: compute expected outputs from the queued operands and compare
  always @(negedge clk) begin
    longint m, ua, ub, sa, sb, sd;
    if (!rst_n) begin
      q.delete();
      exp_diff = '0;
      exp_bout = 1'b0;
      exp_ovf  = 1'b0;
      exp_zero = 1'b1;
    end
    busy_exp = 1'b0;
    foreach (q[i]) begin
      if (cyc >= q[i].k + 1 && cyc <= q[i].k + W) busy_exp = 1'b1;
    end
    done_exp = (q.size() > 0) && (cyc == q[0].k + W + 1);
    if (done_exp) begin
      m  = longint'(1) << W;
      ua = longint'(q[0].a);
      ub = longint'(q[0].b);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      sd = sa - sb;
      exp_diff = W'((ua - ub + m) % m);
      exp_bout = (ua < ub);
      exp_ovf  = (sd < -(m / 2)) || (sd > (m / 2 - 1));
      exp_zero = (exp_diff == '0);
      void'(q.pop_front());
    end
    chk("done", 32'(done), 32'(done_exp));
    chk("busy", 32'(busy), 32'(busy_exp));
    chk("diff", 32'(diff), 32'(exp_diff));
    chk("bout", 32'(bout), 32'(exp_bout));
    chk("ovf",  32'(ovf),  32'(exp_ovf));
    chk("zero", 32'(zero), 32'(exp_zero));
  end

  // Launch one operation on the next free edge, then drop start
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    while (cyc < free_at) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    a_in  = av;
    b_in  = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
  endtask

  // One operation with optional stray start pulses while it is shifting
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise);
    launch(av, bv);
    for (int i = 0; i < W; i++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  logic [W-1:0] dir_a [5] = '{8'd100, 8'h05, 8'h80, 8'h5A, 8'h00};
  logic [W-1:0] dir_b [5] = '{8'd37,  8'h09, 8'h01, 8'h5A, 8'hFF};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Directed corner cases, the first with stray starts while shifting
    for (int i = 0; i < 5; i++) begin
      run_op(dir_a[i], dir_b[i], i == 0);
    end

    // Randomised operations with random stray starts
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b1);
    end

    // Start held high: back-to-back operations, operands changing each cycle
    @(posedge clk);
    #1;
    start = 1'b1;
    for (int i = 0; i < 6 * (W + 1); i++) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;

    // Asynchronous reset during the fourth shift cycle aborts the operation
    launch(8'hC3, 8'h3C);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_diff", 32'(diff), 32'h0);
    chk("rst_bout", 32'(bout), 32'h0);
    chk("rst_ovf",  32'(ovf),  32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    run_op(8'h10, 8'h20, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0);

    repeat (W + 3) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
